// File: rtl/ex_mdu.sv
// Iterative multiply/divide unit for the EX stage: 32-cycle shift-add multiply and
// restoring divide over operand magnitudes, with HI/LO registers and pipeline stall request.
module ex_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             mfhi_i,
    input  logic             mflo_i,
    output logic [WIDTH-1:0] mdu_out_o,
    output logic             busy_o,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d, m_q, m_d;
    logic [63:0] work_q, work_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic        op_legal, accept, is_mul, signed_in;
    logic [31:0] abs_a, abs_b;
    logic [32:0] mul_sum, div_sh, div_diff;
    logic [63:0] mul_nxt, div_nxt, step_nxt, prod_s;
    logic [31:0] quo_s, rem_s, res_hi, res_lo;

    assign op_legal  = (op_i >= OP_MULT) && (op_i <= OP_MTLO);
    assign accept    = valid_i && !busy_q && op_legal;
    assign signed_in = (op_i == OP_MULT) || (op_i == OP_DIV);
    assign abs_a     = (signed_in && a_i[31]) ? (32'd0 - a_i) : a_i;
    assign abs_b     = (signed_in && b_i[31]) ? (32'd0 - b_i) : b_i;
    assign is_mul    = (op_q == OP_MULT) || (op_q == OP_MULTU);

    // work_q holds {partial product} for multiply, {remainder, dividend/quotient} for divide
    assign mul_sum  = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, m_q} : 33'd0);
    assign mul_nxt  = {mul_sum, work_q[31:1]};
    assign div_sh   = work_q[63:31];
    assign div_diff = div_sh - {1'b0, m_q};
    assign div_nxt  = div_diff[32] ? {div_sh[31:0], work_q[30:0], 1'b0}
                                   : {div_diff[31:0], work_q[30:0], 1'b1};
    assign step_nxt = is_mul ? mul_nxt : div_nxt;

    always_comb begin
        prod_s = mul_nxt;
        quo_s  = div_nxt[31:0];
        rem_s  = div_nxt[63:32];
        if (op_q == OP_MULT && (a_q[31] ^ b_q[31])) prod_s = 64'd0 - mul_nxt;
        if (op_q == OP_DIV) begin
            if (a_q[31] ^ b_q[31]) quo_s = 32'd0 - div_nxt[31:0];
            if (a_q[31])           rem_s = 32'd0 - div_nxt[63:32];
        end
        if (is_mul) begin
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
        end else if (b_q == 32'd0) begin
            res_hi = a_q;
            res_lo = 32'hFFFF_FFFF;
        end else begin
            res_hi = rem_s;
            res_lo = quo_s;
        end
    end

    always_comb begin
        busy_d = busy_q;
        done_d = 1'b0;
        cnt_d  = cnt_q;
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;
        m_d    = m_q;
        work_d = work_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (busy_q) begin
            cnt_d  = cnt_q - 6'd1;
            work_d = step_nxt;
            if (cnt_q == 6'd1) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                hi_d   = res_hi;
                lo_d   = res_lo;
            end
        end else if (accept) begin
            if (op_i == OP_MTHI) begin
                hi_d = a_i;
            end else if (op_i == OP_MTLO) begin
                lo_d = a_i;
            end else begin
                busy_d = 1'b1;
                cnt_d  = 6'd32;
                op_d   = op_i;
                a_d    = a_i;
                b_d    = b_i;
                if (op_i == OP_DIV || op_i == OP_DIVU) begin
                    m_d    = abs_b;
                    work_d = {32'd0, abs_a};
                end else begin
                    m_d    = abs_a;
                    work_d = {32'd0, abs_b};
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= 6'd0;
            op_q   <= 3'd0;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            m_q    <= 32'd0;
            work_q <= 64'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            m_q    <= m_d;
            work_q <= work_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    assign stall_o   = !rst_i && busy_q && valid_i && (op_legal || mfhi_i || mflo_i);
    assign mdu_out_o = mfhi_i ? hi_q : lo_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;
endmodule

// File: tb/tb_ex_mdu.sv
// Directed bench for ex_mdu: hand-computed MULT/DIV results, stall behaviour,
// MTHI/MTLO ordering and mid-operation reset.
module tb_ex_mdu;
    logic        clk = 1'b0;
    logic        rst, valid, mfhi, mflo;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [31:0] mdu_out, hi, lo;
    logic        busy, stall, done;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc;

    ex_mdu #(.WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .op_i(op), .a_i(a), .b_i(b),
        .mfhi_i(mfhi), .mflo_i(mflo), .mdu_out_o(mdu_out), .busy_o(busy),
        .stall_o(stall), .done_o(done), .hi_o(hi), .lo_o(lo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        valid = 1'b1; op = o; a = x; b = y;
        step();
        valid = 1'b0; op = 3'd0;
    endtask

    // counts edges from acceptance until done is seen, bounded
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        issue(o, x, y);
        wait_done(n);
        check({tag, "_cycles"}, 64'(n), 64'd32);
        check({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
        check({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
    endtask

    initial begin
        rst = 1'b1; valid = 1'b1; op = 3'd1; a = 32'd5; b = 32'd5; mfhi = 1'b1; mflo = 1'b0;
        step();
        check("rst_stall", {63'd0, stall}, 64'd0);
        step();
        valid = 1'b0; op = 3'd0; mfhi = 1'b0;
        rst = 1'b0;
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);

        issue(3'd1, 32'd7, 32'd6);
        check("mult_busy_e0", {63'd0, busy}, 64'd1);
        wait_done(cyc);
        check("mult76_cycles", 64'(cyc), 64'd32);
        check("mult76_done", {63'd0, done}, 64'd1);
        check("mult76_busy_clr", {63'd0, busy}, 64'd0);
        check("mult76_hi", {32'd0, hi}, 64'd0);
        mflo = 1'b1; #1;
        check("mult76_out_lo", {32'd0, mdu_out}, 64'h2A);
        mflo = 1'b0;
        step();
        check("done_one_cycle", {63'd0, done}, 64'd0);

        run_op("mult_neg", 3'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("mult_big", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
        run_op("div_neg7", 3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_zero", 3'd4, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
        run_op("div_zero", 3'd3, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run_op("divu_100_7", 3'd4, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("div_pos_neg", 3'd3, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2);

        // MFHI held behind a multiply: stalled from the cycle after E1 until done
        issue(3'd1, 32'h0001_0000, 32'h0003_0000);
        step();
        valid = 1'b1; op = 3'd0; mfhi = 1'b1;
        #1;
        cyc = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (stall) cyc++;
            step();
        end
        check("mfhi_stall_cycles", 64'(cyc), 64'd31);
        check("mfhi_stall_clr", {63'd0, stall}, 64'd0);
        check("mfhi_out", {32'd0, mdu_out}, 64'd3);
        valid = 1'b0; mfhi = 1'b0;
        step();

        issue(3'd6, 32'h1234_5678, 32'd0);
        check("mtlo_lo", {32'd0, lo}, 64'h1234_5678);
        check("mtlo_busy", {63'd0, busy}, 64'd0);
        check("mtlo_done", {63'd0, done}, 64'd0);

        // MTHI held during a busy multiply lands after E32 and wins
        issue(3'd1, 32'hFFFF_FFFF, 32'd2);
        valid = 1'b1; op = 3'd5; a = 32'hAAAA_5555;
        #1;
        check("mthi_stalled", {63'd0, stall}, 64'd1);
        wait_done(cyc);
        check("mthi_e32_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        check("mthi_e32_stall", {63'd0, stall}, 64'd0);
        step();
        valid = 1'b0; op = 3'd0;
        check("mthi_applied", {32'd0, hi}, 64'hAAAA_5555);
        check("mthi_no_busy", {63'd0, busy}, 64'd0);
        check("mthi_no_done", {63'd0, done}, 64'd0);

        valid = 1'b0; op = 3'd6; a = 32'd5;
        step();
        op = 3'd0;
        check("invalid_ignored", {32'd0, lo}, 64'hFFFF_FFFE);

        issue(3'd4, 32'd1000, 32'd3);
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hi", {32'd0, hi}, 64'd0);
        check("abort_lo", {32'd0, lo}, 64'd0);
        cyc = 0;
        repeat (30) begin
            if (done) cyc++;
            step();
        end
        check("abort_no_done", 64'(cyc), 64'd0);
        run_op("mult33", 3'd1, 32'd3, 32'd3, 32'd0, 32'd9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
